// File: rtl/mem_rsp_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_rsp_rr_arb
// Brief    : Round-robin arbiter sharing one registered memory-response channel
//            among NUM_INPUTS sources; winner index appended to the tag LSBs.
//            Optional perf counters enabled by defining MEM_RSP_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
module mem_rsp_rr_arb #(
    parameter int NUM_INPUTS     = 4,
    parameter int DATA_WIDTH     = 512,
    parameter int TAG_IN_WIDTH   = 8,
    parameter int LOG_NUM_INPUTS = $clog2(NUM_INPUTS),
    parameter int TAG_OUT_WIDTH  = TAG_IN_WIDTH + LOG_NUM_INPUTS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_tag,
    output logic [NUM_INPUTS-1:0]              in_ready,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [TAG_OUT_WIDTH-1:0]           out_tag,
    input  logic                               out_ready
`ifdef MEM_RSP_ARB_PERF_EN
    ,
    output logic [43:0]                        perf_stall_cycles,
    output logic [43:0]                        perf_conflict_cycles
`endif
);

    localparam logic [LOG_NUM_INPUTS:0]   c_num_inputs = (LOG_NUM_INPUTS+1)'(NUM_INPUTS);
    localparam logic [LOG_NUM_INPUTS-1:0] c_last_idx   = LOG_NUM_INPUTS'(NUM_INPUTS - 1);
    localparam logic [NUM_INPUTS-1:0]     c_one_hot0   = NUM_INPUTS'(1);

    generate
        if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
            $error("mem_rsp_rr_arb: NUM_INPUTS must be in 2..16");
        end
        if (LOG_NUM_INPUTS != $clog2(NUM_INPUTS) ||
            TAG_OUT_WIDTH != TAG_IN_WIDTH + LOG_NUM_INPUTS) begin : g_bad_derived
            $error("mem_rsp_rr_arb: derived parameters must not be overridden");
        end
    endgenerate

    logic [LOG_NUM_INPUTS-1:0] r_ptr;
    logic                      r_out_valid;
    logic [DATA_WIDTH-1:0]     r_out_data;
    logic [TAG_OUT_WIDTH-1:0]  r_out_tag;

    logic [LOG_NUM_INPUTS:0]   w_scan;
    logic [LOG_NUM_INPUTS-1:0] w_win_idx;
    logic [LOG_NUM_INPUTS-1:0] w_ptr_next;
    logic                      w_any_valid;
    logic                      w_can_accept;
    logic                      w_fire;

    // Scan from the pointer upward with explicit modulo so non-power-of-2 counts wrap correctly.
    always_comb begin
        w_scan      = '0;
        w_win_idx   = '0;
        w_any_valid = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_scan = {1'b0, r_ptr} + (LOG_NUM_INPUTS+1)'(k);
            if (w_scan >= c_num_inputs) begin
                w_scan = w_scan - c_num_inputs;
            end
            if (!w_any_valid && in_valid[w_scan[LOG_NUM_INPUTS-1:0]]) begin
                w_any_valid = 1'b1;
                w_win_idx   = w_scan[LOG_NUM_INPUTS-1:0];
            end
        end
    end

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_fire       = w_any_valid && w_can_accept && !reset;
    assign w_ptr_next   = (w_win_idx == c_last_idx) ? '0 : w_win_idx + 1'b1;
    assign in_ready     = w_fire ? (c_one_hot0 << w_win_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_ptr       <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
            r_out_tag   <= {in_tag[w_win_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], w_win_idx};
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

`ifdef MEM_RSP_ARB_PERF_EN
    logic [43:0] r_perf_stall;
    logic [43:0] r_perf_conflict;
    logic        w_conflict;

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign w_conflict = |(in_valid & (in_valid - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall    <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (r_out_valid && !out_ready && !(&r_perf_stall)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (w_conflict && !(&r_perf_conflict)) begin
                r_perf_conflict <= r_perf_conflict + 1'b1;
            end
        end
    end

    assign perf_stall_cycles    = r_perf_stall;
    assign perf_conflict_cycles = r_perf_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_rsp_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rsp_rr_arb
// Brief    : Directed self-checking bench for mem_rsp_rr_arb (N=4 and N=3).
// Revision : 1.0
// ============================================================================
module tb_mem_rsp_rr_arb;

    localparam int DW = 16;
    localparam int TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [3:0]      iv4;
    logic [4*DW-1:0] id4;
    logic [4*TW-1:0] it4;
    logic [3:0]      ir4;
    logic            ov4;
    logic [DW-1:0]   od4;
    logic [TW+1:0]   ot4;
    logic            or4;

    logic [2:0]      iv3;
    logic [3*DW-1:0] id3;
    logic [3*TW-1:0] it3;
    logic [2:0]      ir3;
    logic            ov3;
    logic [DW-1:0]   od3;
    logic [TW+1:0]   ot3;
    logic            or3;

`ifdef MEM_RSP_ARB_PERF_EN
    logic [43:0] ps4, pc4, ps3, pc3;
`endif

    mem_rsp_rr_arb #(.NUM_INPUTS(4), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(iv4), .in_data(id4), .in_tag(it4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_tag(ot4), .out_ready(or4)
`ifdef MEM_RSP_ARB_PERF_EN
        , .perf_stall_cycles(ps4), .perf_conflict_cycles(pc4)
`endif
    );

    mem_rsp_rr_arb #(.NUM_INPUTS(3), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(iv3), .in_data(id3), .in_tag(it3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_tag(ot3), .out_ready(or3)
`ifdef MEM_RSP_ARB_PERF_EN
        , .perf_stall_cycles(ps3), .perf_conflict_cycles(pc3)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]    eh4;
        logic [2:0]    eh3;
        logic [TW+1:0] etag;

        reset = 1'b1;
        iv4   = 4'hF;
        iv3   = 3'b000;
        or4   = 1'b1;
        or3   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id4[i*DW +: DW] = DW'(16'hA000 + i);
            it4[i*TW +: TW] = TW'(8'h10 + i);
        end
        for (int i = 0; i < 3; i++) begin
            id3[i*DW +: DW] = DW'(16'hB000 + i);
            it3[i*TW +: TW] = TW'(8'h20 + i);
        end
        tick;
        tick;

        // Reset state; in_ready held low while reset is high even with valids set
        chk("rst_in_ready", 64'(ir4), 64'h0);
        chk("rst_out_valid", 64'(ov4), 64'h0);
        chk("rst_out_data", 64'(od4), 64'h0);
        chk("rst_out_tag", 64'(ot4), 64'h0);
        chk("rst_ptr", 64'(dut4.r_ptr), 64'h0);

        // Single source 2 with tag 0x5A
        reset = 1'b0;
        iv4   = 4'b0100;
        it4[2*TW +: TW] = 8'h5A;
        id4[2*DW +: DW] = 16'hC2C2;
        #1;
        chk("single_in_ready", 64'(ir4), 64'h4);
        tick;
        chk("single_out_valid", 64'(ov4), 64'h1);
        chk("single_out_tag", 64'(ot4), 64'h16A);
        chk("single_out_data", 64'(od4), 64'hC2C2);
        chk("single_ptr", 64'(dut4.r_ptr), 64'h3);
        iv4 = 4'b0000;
        it4[2*TW +: TW] = 8'h12;
        id4[2*DW +: DW] = 16'hA002;
        tick;
        chk("single_drain", 64'(ov4), 64'h0);

        // All four valid from reset: grants 0,1,2,3,0,1
        reset = 1'b1;
        tick;
        reset = 1'b0;
        iv4   = 4'hF;
        for (int j = 0; j < 6; j++) begin
            eh4  = 4'(1 << (j % 4));
            etag = {TW'(8'h10 + (j % 4)), 2'(j % 4)};
            #1;
            chk("rr4_in_ready", 64'(ir4), 64'(eh4));
            tick;
            chk("rr4_out_valid", 64'(ov4), 64'h1);
            chk("rr4_out_tag", 64'(etag), 64'(ot4) ^ 64'(etag) ^ 64'(etag) ^ 64'(ot4) ^ 64'(ot4));
            chk("rr4_out_data", 64'(od4), 64'(16'hA000 + (j % 4)));
        end
        chk("rr4_ptr", 64'(dut4.r_ptr), 64'h2);

        // Backpressure for 5 cycles with sources 1 and 3 valid
        iv4 = 4'b1010;
        or4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 64'(ir4), 64'h0);
            tick;
            chk("bp_out_valid", 64'(ov4), 64'h1);
            chk("bp_out_tag", 64'(ot4), 64'({8'h11, 2'd1}));
            chk("bp_out_data", 64'(od4), 64'hA001);
        end
        chk("bp_ptr", 64'(dut4.r_ptr), 64'h2);
        or4 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(ir4), 64'h8);
        tick;
        chk("bp_release_tag", 64'(ot4), 64'({8'h13, 2'd3}));
        chk("bp_release_ptr", 64'(dut4.r_ptr), 64'h0);
        #1;
        chk("bp_next_ready", 64'(ir4), 64'h2);
        tick;
        chk("bp_next_tag", 64'(ot4), 64'({8'h11, 2'd1}));
        chk("bp_next_valid", 64'(ov4), 64'h1);

        // Reset while a response is pending
        reset = 1'b1;
        iv4   = 4'hF;
        #1;
        chk("midrst_in_ready", 64'(ir4), 64'h0);
        tick;
        chk("midrst_out_valid", 64'(ov4), 64'h0);
        chk("midrst_out_tag", 64'(ot4), 64'h0);
        chk("midrst_ptr", 64'(dut4.r_ptr), 64'h0);
        reset = 1'b0;
        #1;
        chk("midrst_first_ready", 64'(ir4), 64'h1);
        tick;
        chk("midrst_first_tag", 64'(ot4), 64'({8'h10, 2'd0}));
        iv4 = 4'b0000;

        // Non-power-of-2 wrap: N=3 grants 0,1,2,0
        iv3 = 3'b111;
        for (int j = 0; j < 4; j++) begin
            eh3  = 3'(1 << (j % 3));
            etag = {TW'(8'h20 + (j % 3)), 2'(j % 3)};
            #1;
            chk("rr3_in_ready", 64'(ir3), 64'(eh3));
            tick;
            chk("rr3_out_valid", 64'(ov3), 64'h1);
            chk("rr3_out_tag_lsb", 64'(ot3[1:0]), 64'(j % 3));
            chk("rr3_out_tag", 64'(ot3), 64'(etag));
            chk("rr3_out_data", 64'(od3), 64'(16'hB000 + (j % 3)));
        end
        iv3 = 3'b000;

`ifdef MEM_RSP_ARB_PERF_EN
        reset = 1'b1;
        iv4   = 4'b0000;
        tick;
        chk("perf_rst_stall", 64'(ps4), 64'h0);
        chk("perf_rst_conflict", 64'(pc4), 64'h0);
        reset = 1'b0;
        iv4   = 4'b0001;
        or4   = 1'b0;
        tick;
        iv4 = 4'b0000;
        tick;
        tick;
        tick;
        or4 = 1'b1;
        iv4 = 4'b0011;
        tick;
        tick;
        iv4 = 4'b0000;
        chk("perf_stall", 64'(ps4), 64'h3);
        chk("perf_conflict", 64'(pc4), 64'h2);
`endif

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
